ika3012_sodec: RTL

Serial-audio receiver for the OPM core's SO/SH1/SH2 output stream, emulating the YM3012 input stage. It samples the serial floating-point sample stream on phi1 negative-edge clock enables and latches left/right words on SH1/SH2 falling edges. It checks frame spacing and converts each 13-bit mantissa/exponent word to a 16-bit signed linear sample. It sits between the OPM core's serial output and the board-level audio mixer/DAC wrapper.

---
 rtl/ika3012_sodec.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ika3012_sodec.sv
// ika3012_sodec: YM3012-style serial audio receiver. Deserialises the OPM
// SO stream on phi1 clock enables, latches words on SH1/SH2 falling edges,
// checks frame spacing and converts 13-bit float words to 16-bit linear.
module ika3012_sodec #(
  parameter bit MUTE_ON_UNLOCK = 1'b1
) (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_L,
  output logic [15:0] o_R,
  output logic        o_L_VALID,
  output logic        o_R_VALID,
  output logic        o_LOCKED,
  output logic        o_FRAME_ERR
);

  logic        cen;
  logic [15:0] sr;
  logic        sh1_q;
  logic        sh2_q;
  logic [4:0]  cnt;
  logic        fall1;
  logic        fall2;
  logic        single_fall;
  logic        both_fall;
  logic        good_fall;

  logic        lat_good;
  logic        lat_bad;
  logic        lat_ch;
  logic [12:0] lat_word;

  logic [9:0]  mant_s;
  logic [2:0]  expo;
  logic [15:0] mant_x;
  logic [15:0] dec_next;

  logic        dec_vld;
  logic        dec_ch;
  logic        mute_pend;
  logic [15:0] dec_val;

  assign cen         = ~i_phi1_NCEN_n;
  assign fall1       = cen & sh1_q & ~i_SH1;
  assign fall2       = cen & sh2_q & ~i_SH2;
  assign single_fall = fall1 ^ fall2;
  assign both_fall   = fall1 & fall2;
  assign good_fall   = single_fall & (cnt == 5'd16);

  // Serial front end: shift register, SH edge history and spacing counter
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      sr    <= '0;
      sh1_q <= 1'b0;
      sh2_q <= 1'b0;
      cnt   <= 5'd31;
    end else if (cen) begin
      sr    <= {i_SO, sr[15:1]};
      sh1_q <= i_SH1;
      sh2_q <= i_SH2;
      if (both_fall) begin
        cnt <= 5'd31;
      end else if (single_fall) begin
        cnt <= 5'd1;
      end else if (cnt != 5'd31) begin
        cnt <= cnt + 5'd1;
      end
    end
  end

  // Latch stage: capture the pre-shift word and classify the event
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      lat_good <= 1'b0;
      lat_bad  <= 1'b0;
      lat_ch   <= 1'b0;
      lat_word <= '0;
    end else begin
      lat_good <= good_fall;
      lat_bad  <= both_fall | (single_fall & ~good_fall);
      if (single_fall) begin
        lat_ch   <= fall2;
        lat_word <= sr[15:3];
      end
    end
  end

  // Float-to-linear: flipping the offset-binary MSB gives two's complement
  always_comb begin
    mant_s   = {~lat_word[9], lat_word[8:0]};
    expo     = lat_word[12:10];
    mant_x   = {{6{mant_s[9]}}, mant_s};
    dec_next = '0;
    if (expo != 3'd0) begin
      dec_next = mant_x << (expo - 3'd1);
    end
  end

  // Decode stage: register linear value, report error and lock state
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      dec_vld     <= 1'b0;
      dec_ch      <= 1'b0;
      dec_val     <= '0;
      mute_pend   <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      o_LOCKED    <= 1'b0;
    end else begin
      dec_vld     <= lat_good;
      dec_ch      <= lat_ch;
      dec_val     <= dec_next;
      mute_pend   <= MUTE_ON_UNLOCK & lat_bad & o_LOCKED;
      o_FRAME_ERR <= lat_bad;
      if (lat_good) begin
        o_LOCKED <= 1'b1;
      end else if (lat_bad) begin
        o_LOCKED <= 1'b0;
      end
    end
  end

  // Output stage: publish to the addressed channel, or mute on lock loss
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      o_L       <= '0;
      o_R       <= '0;
      o_L_VALID <= 1'b0;
      o_R_VALID <= 1'b0;
    end else begin
      o_L_VALID <= dec_vld & ~dec_ch;
      o_R_VALID <= dec_vld & dec_ch;
      if (dec_vld & ~dec_ch) begin
        o_L <= dec_val;
      end
      if (dec_vld & dec_ch) begin
        o_R <= dec_val;
      end
      if (mute_pend) begin
        o_L <= '0;
        o_R <= '0;
      end
    end
  end

endmodule
